// File: rtl/pathfinding_pkg.sv
// pathfinding_pkg: shared A* node types and explored-set sizing
package pathfinding_pkg;
  localparam int NODE_W = 272;
  localparam int EXPLORED_DEPTH = 101;
  localparam int EXPLORED_AW = 7;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] cost;
    logic [31:0] flags;
  } map_node;
  typedef struct packed {
    logic [15:0] node_id;
    logic [15:0] parent_id;
    logic [31:0] g_cost;
    logic [31:0] h_cost;
    logic [31:0] f_cost;
    map_node     node;
    logic [47:0] rsvd;
  } node_info;
  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLR_FILL} clr_state_e;
endpackage

// File: rtl/rr_lock_arbiter2.sv
// rr_lock_arbiter2: 2-way round-robin grant held until the holder's request falls
module rr_lock_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       inhibit,
  output logic [1:0] gnt
);
  logic       last;
  logic [1:0] pick;
  always_comb pick = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
  // last starts at 1 so the first contested grant goes to scanner 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gnt  <= '0;
      last <= 1'b1;
    end else if (gnt != 2'b00) begin
      if ((gnt & req) == 2'b00) gnt <= '0;
    end else if (!inhibit && pick != 2'b00) begin
      gnt  <= pick;
      last <= pick[1];
    end
endmodule

// File: rtl/explored_ram_ctrl.sv
// explored_ram_ctrl: explored-set RAM append/zero-fill control and shared read-port arbitration
module explored_ram_ctrl #(
  parameter int DEPTH  = pathfinding_pkg::EXPLORED_DEPTH,
  parameter int ADDR_W = pathfinding_pkg::EXPLORED_AW,
  parameter int NODE_W = pathfinding_pkg::NODE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              append,
  input  logic [NODE_W-1:0] append_data,
  output logic              append_ack,
  output logic [ADDR_W-1:0] count,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [NODE_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr
);
  import pathfinding_pkg::*;
  clr_state_e        state, state_n;
  logic [ADDR_W-1:0] fill_addr, app_addr;
  logic [NODE_W-1:0] app_data;
  logic              app_we, fill_last;
  always_comb begin
    fill_last = fill_addr == ADDR_W'(DEPTH - 1);
    state_n = state;
    case (state)
      IDLE:     state_n = clear ? (gnt == 2'b00 ? CLR_FILL : CLR_WAIT) : IDLE;
      CLR_WAIT: state_n = gnt == 2'b00 ? CLR_FILL : CLR_WAIT;
      CLR_FILL: state_n = fill_last ? IDLE : CLR_FILL;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fill_addr <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      app_we    <= 1'b0;
      app_addr  <= '0;
      app_data  <= '0;
    end else begin
      app_we    <= 1'b0;
      fill_addr <= state == CLR_FILL ? fill_addr + 1'b1 : '0;
      if (state == CLR_FILL && fill_last) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (state == IDLE && append && !clear) begin
        if (full) overflow <= 1'b1;
        else begin
          app_we   <= 1'b1;
          app_addr <= count;
          app_data <= append_data;
          count    <= count + 1'b1;
        end
      end
    end
  // appends never overlap the fill: they are only accepted in IDLE
  assign busy       = state != IDLE;
  assign full       = count == ADDR_W'(DEPTH);
  assign append_ack = app_we;
  assign ram_we     = app_we | (state == CLR_FILL);
  assign ram_waddr  = state == CLR_FILL ? fill_addr : app_addr;
  assign ram_wdata  = state == CLR_FILL ? '0 : app_data;
  assign ram_raddr  = gnt[0] ? rd_addr0 : gnt[1] ? rd_addr1 : '0;
  rr_lock_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .inhibit (busy | clear),
    .gnt     (gnt)
  );
endmodule

// File: tb/tb_explored_ram_ctrl.sv
// tb_explored_ram_ctrl: scoreboard bench for the explored-set RAM controller
module tb_explored_ram_ctrl;
  import pathfinding_pkg::*;
  localparam int AW = EXPLORED_AW;
  localparam int DEPTH = EXPLORED_DEPTH;
  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [NODE_W-1:0] data;
    logic              ack;
  } wr_t;
  logic              clk = 1'b0, reset_n = 1'b0, clear = 1'b0, append = 1'b0;
  logic [NODE_W-1:0] append_data = '0;
  logic              append_ack, full, overflow, busy, ram_we;
  logic [AW-1:0]     count, ram_waddr, ram_raddr;
  logic [AW-1:0]     rd_addr0 = '0, rd_addr1 = '0;
  logic [1:0]        req = 2'b00, gnt;
  logic [NODE_W-1:0] ram_wdata;
  wr_t               exp_q[$];
  int                checks = 0, errors = 0;
  always #5 clk = ~clk;
  explored_ram_ctrl dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .append(append), .append_data(append_data),
    .append_ack(append_ack), .count(count), .full(full), .overflow(overflow), .busy(busy),
    .req(req), .gnt(gnt), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chkd(input string name, input logic [NODE_W-1:0] act, input logic [NODE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_fill();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(wr_t'{AW'(i), '0, 1'b0});
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      n++;
      tick();
    end
    chk(name, int'(busy), 0);
  endtask
  task automatic do_clear();
    clear = 1'b1;
    push_fill();
    tick();
    clear = 1'b0;
    wait_idle("clear_done");
  endtask
  always @(posedge clk) begin
    #1;
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, no write expected", ram_waddr, ram_wdata);
      end else begin : pop
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(ram_waddr), int'(e.addr));
        chkd("wr_data", ram_wdata, e.data);
        chk("wr_ack", int'(append_ack), int'(e.ack));
      end
    end else if (append_ack) chk("ack_without_we", int'(append_ack), 0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    node_info n;
    int       cyc;
    tick(2);
    chk("rst_count", int'(count), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_ack", int'(append_ack), 0);
    reset_n = 1'b1;
    tick();
    clear = 1'b1;
    push_fill();
    tick();
    clear = 1'b0;
    chk("busy_on_clear", int'(busy), 1);
    cyc = 0;
    while (busy && cyc < 300) begin
      cyc++;
      tick();
    end
    chk("fill_cycles", cyc, DEPTH);
    chk("count_after_fill", int'(count), 0);
    chk("fill_all_written", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      n = '0;
      n.node_id = 16'(5 + i);
      append = 1'b1;
      append_data = n;
      exp_q.push_back(wr_t'{AW'(i), n, 1'b1});
      tick();
    end
    append = 1'b0;
    chk("ack_third", int'(append_ack), 1);
    chk("count_3", int'(count), 3);
    tick();
    chk("ack_drop", int'(append_ack), 0);
    chk("app3_written", exp_q.size(), 0);
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      n = '0;
      n.node_id = 16'(100 + i);
      n.f_cost = 32'(i * 3);
      append = 1'b1;
      append_data = n;
      exp_q.push_back(wr_t'{AW'(i), n, 1'b1});
      tick();
    end
    chk("full_set", int'(full), 1);
    chk("overflow_before", int'(overflow), 0);
    n = '0;
    n.node_id = 16'd999;
    append_data = n;
    tick();
    append = 1'b0;
    chk("overflow_set", int'(overflow), 1);
    chk("count_full", int'(count), DEPTH);
    chk("no_ack_full", int'(append_ack), 0);
    tick();
    chk("full_written", exp_q.size(), 0);
    do_clear();
    chk("overflow_cleared", int'(overflow), 0);
    chk("full_cleared", int'(full), 0);
    chk("count_cleared", int'(count), 0);
    rd_addr0 = 7'd12;
    rd_addr1 = 7'd34;
    req = 2'b11;
    tick();
    chk("arb_both_gnt0", int'(gnt), 1);
    chk("arb_raddr0", int'(ram_raddr), 12);
    req = 2'b10;
    tick();
    chk("arb_gap", int'(gnt), 0);
    chk("arb_raddr_idle", int'(ram_raddr), 0);
    tick();
    chk("arb_gnt1", int'(gnt), 2);
    chk("arb_raddr1", int'(ram_raddr), 34);
    req = 2'b11;
    tick();
    chk("arb_lock_a", int'(gnt), 2);
    tick();
    chk("arb_lock_b", int'(gnt), 2);
    req = 2'b01;
    tick();
    chk("arb_gap2", int'(gnt), 0);
    tick();
    chk("arb_gnt0_again", int'(gnt), 1);
    req = 2'b00;
    tick();
    chk("arb_release", int'(gnt), 0);
    req = 2'b01;
    tick();
    chk("c5_gnt0", int'(gnt), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("c5_busy", int'(busy), 1);
    tick(3);
    chk("c5_no_fill", int'(ram_we), 0);
    chk("c5_gnt_held", int'(gnt), 1);
    req = 2'b00;
    push_fill();
    tick();
    chk("c5_gnt_drop", int'(gnt), 0);
    chk("c5_still_wait", int'(ram_we), 0);
    req = 2'b10;
    tick();
    chk("c5_fill_start", int'(ram_we), 1);
    chk("c5_fill_addr0", int'(ram_waddr), 0);
    chk("c5_no_gnt_fill", int'(gnt), 0);
    tick(50);
    chk("c5_no_gnt_mid", int'(gnt), 0);
    wait_idle("c5_done");
    chk("c5_no_gnt_end", int'(gnt), 0);
    tick();
    chk("c5_gnt1_after", int'(gnt), 2);
    req = 2'b00;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      n = '0;
      n.node_id = 16'(8'h21 + i);
      append = 1'b1;
      append_data = n;
      exp_q.push_back(wr_t'{AW'(i), n, 1'b1});
      tick();
    end
    append = 1'b0;
    chk("c6_count2", int'(count), 2);
    clear = 1'b1;
    push_fill();
    tick();
    clear = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #2;
      cyc++;
    end while (!(ram_we && ram_waddr == 7'd40) && cyc < 200);
    chk("c6_at_40", int'(ram_waddr), 40);
    reset_n = 1'b0;
    #1;
    chk("c6_busy", int'(busy), 0);
    chk("c6_we", int'(ram_we), 0);
    chk("c6_count", int'(count), 0);
    chk("c6_gnt", int'(gnt), 0);
    chk("c6_ack", int'(append_ack), 0);
    chk("c6_overflow", int'(overflow), 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick(5);
    chk("c6_busy_after", int'(busy), 0);
    chk("c6_count_after", int'(count), 0);
    chk("c6_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
